// File: rtl/conv_layer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// conv_ctrl_pkg
// Shared definitions for the two-layer conv engine sequencer: bus widths and
// the state encoding seen by the SRAM address generator on the 4-bit state
// bus.
// -----------------------------------------------------------------------------
package conv_ctrl_pkg;

    localparam int STATE_W = 4;
    localparam int POS_W   = 6;
    localparam int OCH_W   = 5;

    // Encoding is visible on the state bus, so the values are fixed.
    // Codes 7..15 are never produced and fall back to IDLE if ever seen.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_UNSHUFFLE = 4'd1,
        ST_LOAD      = 4'd2,
        ST_CONV1     = 4'd3,
        ST_CONV2     = 4'd4,
        ST_DRAIN     = 4'd5,
        ST_FINISH    = 4'd6
    } state_t;

endpackage

// File: rtl/conv_layer_ctrl_if.sv
// -----------------------------------------------------------------------------
// conv_layer_ctrl_if
// Handshake and status bundle of the conv layer sequencer.
//   start, unshuffle_done, load_done : requests/acknowledges into the sequencer
//   state, conv_done, och_cnt, pos_cnt: sequencing status for the address gen
//   out_valid, out_last               : pipeline-aligned flags for the writer
//   busy, done                        : overall run status
// master = the environment driving the handshakes, slave = the sequencer.
// -----------------------------------------------------------------------------
interface conv_layer_ctrl_if import conv_ctrl_pkg::*; ();

    logic               start;
    logic               unshuffle_done;
    logic               load_done;
    logic [STATE_W-1:0] state;
    logic               conv_done;
    logic [OCH_W-1:0]   och_cnt;
    logic [POS_W-1:0]   pos_cnt;
    logic               out_valid;
    logic               out_last;
    logic               busy;
    logic               done;

    modport master (
        output start, unshuffle_done, load_done,
        input  state, conv_done, och_cnt, pos_cnt,
        input  out_valid, out_last, busy, done
    );

    modport slave (
        input  start, unshuffle_done, load_done,
        output state, conv_done, och_cnt, pos_cnt,
        output out_valid, out_last, busy, done
    );

endinterface

// File: rtl/conv_layer_ctrl_valid_delay_line.sv
// -----------------------------------------------------------------------------
// valid_delay_line
// Fixed-depth shift register that delays a small flag vector by DEPTH cycles,
// used to line the issue flags up with the MAC result.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears every stage
//   din   : flags entering this cycle
//   dout  : flags entered DEPTH cycles ago
// -----------------------------------------------------------------------------
module valid_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] vld_p [DEPTH];

    // stage boundary: one register per cycle of MAC latency, shifting always
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign dout = vld_p[DEPTH-1];

endmodule

// File: rtl/conv_layer_ctrl.sv
// -----------------------------------------------------------------------------
// conv_layer_ctrl
// Top-level sequencer for the two-layer conv engine. Walks
// IDLE -> UNSHUFFLE -> LOAD -> CONV1 -> DRAIN -> LOAD -> CONV2 -> DRAIN
// -> FINISH -> IDLE, counting output positions and channels while convolving
// and flagging each channel boundary on conv_done.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (aborts a run immediately)
//   bus   : slave side of conv_layer_ctrl_if
//           in : start, unshuffle_done, load_done
//           out: state, conv_done, och_cnt, pos_cnt, out_valid, out_last,
//                busy, done
// -----------------------------------------------------------------------------
module conv_layer_ctrl import conv_ctrl_pkg::*; #(
    parameter int C1_POS   = 36,
    parameter int C2_POS   = 25,
    parameter int C1_OCH   = 4,
    parameter int C2_OCH   = 12,
    parameter int PIPE_LAT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    conv_layer_ctrl_if.slave bus
);

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [POS_W-1:0] C1_POS_LAST = POS_W'(C1_POS - 1);
    localparam logic [POS_W-1:0] C2_POS_LAST = POS_W'(C2_POS - 1);
    localparam logic [OCH_W-1:0] C1_OCH_LAST = OCH_W'(C1_OCH - 1);
    localparam logic [OCH_W-1:0] C2_OCH_LAST = OCH_W'(C2_OCH - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST  = DRN_W'(PIPE_LAT - 1);

    state_t           state_q, state_d;
    logic             layer_q, layer_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [OCH_W-1:0] och_q, och_d;
    logic [DRN_W-1:0] drain_q, drain_d;

    logic issue;
    logic pos_last;
    logic och_last;

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        pos_d    = pos_q;
        och_d    = och_q;
        drain_d  = '0;
        issue    = 1'b0;
        pos_last = 1'b0;
        och_last = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_UNSHUFFLE;
            end
            ST_UNSHUFFLE: begin
                if (bus.unshuffle_done) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.load_done) state_d = layer_q ? ST_CONV2 : ST_CONV1;
            end
            ST_CONV1, ST_CONV2: begin
                issue = 1'b1;
                if (state_q == ST_CONV1) begin
                    pos_last = (pos_q == C1_POS_LAST);
                    och_last = (och_q == C1_OCH_LAST);
                end else begin
                    pos_last = (pos_q == C2_POS_LAST);
                    och_last = (och_q == C2_OCH_LAST);
                end
                if (pos_last) begin
                    pos_d = '0;
                    if (och_last) begin
                        och_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        och_d = och_q + 1'b1;
                    end
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Hold off until the last issued address has come out of the MAC.
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    if (!layer_q) begin
                        layer_d = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                layer_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            layer_q <= 1'b0;
            pos_q   <= '0;
            och_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            pos_q   <= pos_d;
            och_q   <= och_d;
            drain_q <= drain_d;
        end
    end

    // stage boundary: issue flags -> MAC-result-aligned flags
    logic [1:0] flags_p0;
    logic [1:0] flags_pn;

    assign flags_p0 = {issue & pos_last & och_last, issue};

    valid_delay_line #(
        .DEPTH (PIPE_LAT),
        .WIDTH (2)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (flags_p0),
        .dout  (flags_pn)
    );

    // conv_done is a pure decode of registered state so it lines up with the
    // address issued in the same cycle.
    assign bus.state     = state_q;
    assign bus.conv_done = pos_last;
    assign bus.och_cnt   = och_q;
    assign bus.pos_cnt   = pos_q;
    assign bus.out_valid = flags_pn[0];
    assign bus.out_last  = flags_pn[1];
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_FINISH);

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_ctrl
// Drives two sequencers (default parameters and a minimal-size variant) with
// randomized handshake timing plus random illegal handshakes, and checks every
// cycle against an expected trace built from the layer schedule.
// -----------------------------------------------------------------------------
module tb_conv_layer_ctrl;
    import conv_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    conv_layer_ctrl_if m_if ();
    conv_layer_ctrl_if e_if ();

    conv_layer_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    conv_layer_ctrl #(
        .C1_POS   (1),
        .C1_OCH   (1),
        .PIPE_LAT (1)
    ) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (e_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected trace: one entry per clock cycle.
    int q_st  [$];
    int q_pos [$];
    int q_och [$];
    bit q_cd  [$];
    bit q_iss [$];
    bit q_lst [$];
    bit q_hs_s[$];
    bit q_hs_u[$];
    bit q_hs_l[$];

    function automatic void push_cyc(input int st, input int pos, input int och,
                                     input bit cd, input bit lst,
                                     input bit hs_s, input bit hs_u, input bit hs_l);
        q_st.push_back(st);
        q_pos.push_back(pos);
        q_och.push_back(och);
        q_cd.push_back(cd);
        q_iss.push_back(st == 3 || st == 4);
        q_lst.push_back(lst);
        q_hs_s.push_back(hs_s);
        q_hs_u.push_back(hs_u);
        q_hs_l.push_back(hs_l);
    endfunction

    // Builds the whole-network schedule: start, unshuffle wait, two load/conv/
    // drain passes, finish, then some idle cycles.
    task automatic build_trace(input int p1, input int o1, input int p2, input int o2,
                               input int lat, input int du, input int dl1,
                               input int dl2, input int tail);
        q_st.delete(); q_pos.delete(); q_och.delete(); q_cd.delete();
        q_iss.delete(); q_lst.delete(); q_hs_s.delete(); q_hs_u.delete(); q_hs_l.delete();
        push_cyc(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < du; i++)  push_cyc(1, 0, 0, 0, 0, 0, i == du - 1, 0);
        for (int i = 0; i < dl1; i++) push_cyc(2, 0, 0, 0, 0, 0, 0, i == dl1 - 1);
        for (int i = 0; i < p1 * o1; i++)
            push_cyc(3, i % p1, i / p1, (i % p1) == p1 - 1, i == p1 * o1 - 1, 0, 0, 0);
        for (int i = 0; i < lat; i++) push_cyc(5, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < dl2; i++) push_cyc(2, 0, 0, 0, 0, 0, 0, i == dl2 - 1);
        for (int i = 0; i < p2 * o2; i++)
            push_cyc(4, i % p2, i / p2, (i % p2) == p2 - 1, i == p2 * o2 - 1, 0, 0, 0);
        for (int i = 0; i < lat; i++) push_cyc(5, 0, 0, 0, 0, 0, 0, 0);
        push_cyc(6, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < tail; i++) push_cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive_idle();
        m_if.start = 1'b0; m_if.unshuffle_done = 1'b0; m_if.load_done = 1'b0;
        e_if.start = 1'b0; e_if.unshuffle_done = 1'b0; e_if.load_done = 1'b0;
    endtask

    // Called at posedge+1. Stops after the comparison of cycle stop_at (if >= 0).
    task automatic run_trace(input bit edge_dut, input int lat, input int p1, input int o1,
                             input int p2, input int o2, input int noise_den,
                             input int stop_at, input bit check_totals, input string tag);
        logic [19:0] obs, want;
        bit ns, nu, nl, vld, lst;
        int n_cd, n_v, n_l, n_done;
        int t_conv1, t_v, t_lastiss, t_ol, t_done;
        n_cd = 0; n_v = 0; n_l = 0; n_done = 0;
        t_conv1 = -1; t_v = -1; t_lastiss = -1; t_ol = -1; t_done = -1;
        for (int k = 0; k < q_st.size(); k++) begin
            ns = (q_st[k] != 0) && ($urandom_range(0, noise_den - 1) == 0);
            nu = (q_st[k] != 1) && ($urandom_range(0, noise_den - 1) == 0);
            nl = (q_st[k] != 2) && ($urandom_range(0, noise_den - 1) == 0);
            if (edge_dut) begin
                e_if.start = q_hs_s[k] | ns;
                e_if.unshuffle_done = q_hs_u[k] | nu;
                e_if.load_done = q_hs_l[k] | nl;
            end else begin
                m_if.start = q_hs_s[k] | ns;
                m_if.unshuffle_done = q_hs_u[k] | nu;
                m_if.load_done = q_hs_l[k] | nl;
            end
            @(negedge clk);
            if (edge_dut)
                obs = {e_if.state, e_if.pos_cnt, e_if.och_cnt, e_if.conv_done,
                       e_if.out_valid, e_if.out_last, e_if.busy, e_if.done};
            else
                obs = {m_if.state, m_if.pos_cnt, m_if.och_cnt, m_if.conv_done,
                       m_if.out_valid, m_if.out_last, m_if.busy, m_if.done};
            vld = (k >= lat) ? q_iss[k - lat] : 1'b0;
            lst = (k >= lat) ? q_lst[k - lat] : 1'b0;
            want = {4'(q_st[k]), 6'(q_pos[k]), 5'(q_och[k]), q_cd[k], vld, lst,
                    q_st[k] != 0, q_st[k] == 6};
            n_cmp++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL %s cycle %0d: got st=%0d pos=%0d och=%0d flags(cd,v,l,busy,done)=%b, expected st=%0d pos=%0d och=%0d flags=%b",
                         tag, k, obs[19:16], obs[15:10], obs[9:5], obs[4:0],
                         want[19:16], want[15:10], want[9:5], want[4:0]);
            end
            if (obs[4]) n_cd++;
            if (obs[3]) begin n_v++; if (t_v < 0) t_v = k; end
            if (obs[2]) begin n_l++; t_ol = k; end
            if (obs[0]) begin n_done++; t_done = k; end
            if (obs[19:16] == 4'd3 && t_conv1 < 0) t_conv1 = k;
            if (obs[19:16] == 4'd4) t_lastiss = k;
            if (k == stop_at) break;
            @(posedge clk);
            #1;
        end
        if (stop_at < 0) drive_idle();
        if (check_totals) begin
            n_cmp++;
            if (n_cd !== o1 + o2) begin
                n_err++;
                $display("FAIL %s conv_done_count: got %0d, expected %0d", tag, n_cd, o1 + o2);
            end
            n_cmp++;
            if (n_v !== p1 * o1 + p2 * o2) begin
                n_err++;
                $display("FAIL %s out_valid_count: got %0d, expected %0d", tag, n_v, p1 * o1 + p2 * o2);
            end
            n_cmp++;
            if (n_l !== 2) begin
                n_err++;
                $display("FAIL %s out_last_count: got %0d, expected 2", tag, n_l);
            end
            n_cmp++;
            if (n_done !== 1) begin
                n_err++;
                $display("FAIL %s done_count: got %0d, expected 1", tag, n_done);
            end
            n_cmp++;
            if (t_v - t_conv1 !== lat) begin
                n_err++;
                $display("FAIL %s first_valid_latency: got %0d, expected %0d", tag, t_v - t_conv1, lat);
            end
            n_cmp++;
            if (t_ol - t_lastiss !== lat) begin
                n_err++;
                $display("FAIL %s last_latency: got %0d, expected %0d", tag, t_ol - t_lastiss, lat);
            end
            n_cmp++;
            if (t_done - t_lastiss !== lat + 1) begin
                n_err++;
                $display("FAIL %s done_latency: got %0d, expected %0d", tag, t_done - t_lastiss, lat + 1);
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (m_if.state !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d, expected 0", m_if.state); end
        n_cmp++;
        if (m_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", m_if.busy); end
        n_cmp++;
        if (m_if.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, expected 0", m_if.done); end
        n_cmp++;
        if (m_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, expected 0", m_if.out_valid); end
        n_cmp++;
        if (m_if.conv_done !== 1'b0) begin n_err++; $display("FAIL reset_conv_done: got %b, expected 0", m_if.conv_done); end
        n_cmp++;
        if ({m_if.out_last, m_if.pos_cnt, m_if.och_cnt} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_counters: got last=%b pos=%0d och=%0d, expected all 0",
                     m_if.out_last, m_if.pos_cnt, m_if.och_cnt);
        end
        n_cmp++;
        if (e_if.state !== 4'd0) begin n_err++; $display("FAIL reset_edge_state: got %0d, expected 0", e_if.state); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_run(input int du, input string tag);
        build_trace(36, 4, 25, 12, 3, du, $urandom_range(1, 6), $urandom_range(1, 6), 4);
        run_trace(1'b0, 3, 36, 4, 25, 12, 8, -1, 1'b1, tag);
    endtask

    task automatic test_illegal_handshakes();
        // Every foreign handshake is held high in every cycle it does not belong to.
        build_trace(36, 4, 25, 12, 3, $urandom_range(1, 5), $urandom_range(1, 5),
                    $urandom_range(1, 5), 4);
        run_trace(1'b0, 3, 36, 4, 25, 12, 1, -1, 1'b1, "illegal");
    endtask

    task automatic test_async_reset();
        int stop;
        stop = -1;
        build_trace(36, 4, 25, 12, 3, $urandom_range(1, 6), $urandom_range(1, 6),
                    $urandom_range(1, 6), 4);
        for (int k = 0; k < q_st.size(); k++) begin
            if (stop < 0 && q_st[k] == 4 && q_och[k] == 5) stop = k;
        end
        stop = stop + $urandom_range(0, 20);
        run_trace(1'b0, 3, 36, 4, 25, 12, 8, stop, 1'b0, "pre_abort");
        // Now at a falling edge: assert reset well away from any rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_if.state !== 4'd0) begin n_err++; $display("FAIL abort_state: got %0d, expected 0", m_if.state); end
        n_cmp++;
        if (m_if.out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid: got %b, expected 0", m_if.out_valid); end
        n_cmp++;
        if ({m_if.busy, m_if.och_cnt, m_if.pos_cnt} !== 12'd0) begin
            n_err++;
            $display("FAIL abort_counters: got busy=%b och=%0d pos=%0d, expected all 0",
                     m_if.busy, m_if.och_cnt, m_if.pos_cnt);
        end
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_full_run($urandom_range(1, 12), "after_abort");
    endtask

    task automatic test_edge_params();
        build_trace(1, 1, 25, 12, 1, $urandom_range(1, 4), $urandom_range(1, 4),
                    $urandom_range(1, 4), 3);
        run_trace(1'b1, 1, 1, 1, 25, 12, 8, -1, 1'b1, "edge");
    endtask

    initial begin
        test_reset();
        test_full_run(10, "full_run");
        test_full_run($urandom_range(1, 12), "back_to_back");
        test_illegal_handshakes();
        test_async_reset();
        test_edge_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
